// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit and its ALU.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StReset   = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExec    = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StJump    = 4'd12,
    StIllegal = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [5:0] FunctAdd = 6'b100000;
  localparam logic [5:0] FunctSub = 6'b100010;
  localparam logic [5:0] FunctAnd = 6'b100100;
  localparam logic [5:0] FunctOr  = 6'b100101;
  localparam logic [5:0] FunctSlt = 6'b101010;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  localparam logic [1:0] AluSrcBReg    = 2'b00;
  localparam logic [1:0] AluSrcBFour   = 2'b01;
  localparam logic [1:0] AluSrcBImm    = 2'b10;
  localparam logic [1:0] AluSrcBImmSh2 = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/alu_op_decode.sv
// R-type funct field to ALU operation decode; funct_valid flags supported functs.
module alu_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_valid
);

  always_comb begin
    alu_op      = AluAnd;
    funct_valid = 1'b1;
    unique case (funct)
      FunctAdd: alu_op = AluAdd;
      FunctSub: alu_op = AluSub;
      FunctAnd: alu_op = AluAnd;
      FunctOr:  alu_op = AluOr;
      FunctSlt: alu_op = AluSlt;
      default:  funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset main control FSM: Moore strobes per state, memory-ready stalls,
// retired-instruction pulse and counter.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic [2:0]             alu_op,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_source,
  output logic                   pc_en,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   retired,
  output logic                   illegal,
  output logic [INSTR_CNT_W-1:0] instr_count,
  output logic [3:0]             state_dbg
);

  state_e                 state_q, state_d;
  logic                   retired_q, retired_d;
  logic [INSTR_CNT_W-1:0] instr_count_q, instr_count_d;
  logic                   pc_write, pc_write_cond;
  logic [2:0]             exec_alu_op;
  logic                   funct_valid;

  alu_op_decode u_alu_op_decode (
    .funct       (funct),
    .alu_op      (exec_alu_op),
    .funct_valid (funct_valid)
  );

  always_comb begin
    state_d       = state_q;
    alu_op        = AluAnd;
    alu_src_a     = 1'b0;
    alu_src_b     = AluSrcBReg;
    pc_source     = PcSrcAlu;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;

    unique case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = AluSrcBFour;
        alu_op    = AluAdd;
        pc_source = PcSrcAlu;
        // IR and PC only commit once the fetch read actually completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alu_src_b = AluSrcBImmSh2;
        alu_op    = AluAdd;
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = funct_valid ? StExec : StIllegal;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default:    state_d = StIllegal;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = AluSrcBImm;
        alu_op    = AluAdd;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = StFetch;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_src_b = AluSrcBReg;
        alu_op    = exec_alu_op;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_src_b     = AluSrcBReg;
        alu_op        = AluSub;
        pc_source     = PcSrcAluOut;
        pc_write_cond = 1'b1;
        state_d       = StFetch;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = AluSrcBImm;
        alu_op    = AluAdd;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StJump: begin
        pc_source = PcSrcJump;
        pc_write  = 1'b1;
        state_d   = StFetch;
      end
      StIllegal: illegal = 1'b1;
      default:   state_d = StIllegal;
    endcase
  end

  assign pc_en = pc_write | (pc_write_cond & zero);

  // An instruction retires on any transition back to FETCH other than from RESET.
  always_comb begin
    retired_d     = 1'b0;
    instr_count_d = instr_count_q;
    if (state_d == StFetch && state_q != StFetch && state_q != StReset) begin
      retired_d     = 1'b1;
      instr_count_d = instr_count_q + INSTR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StReset;
      retired_q     <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      retired_q     <= retired_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign retired     = retired_q;
  assign instr_count = instr_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: vector table, hand-written corner sequences and
// random instruction streams checked against an instruction-level model.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [5:0]  funct = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic [2:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_source;
  logic        pc_en, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, retired, illegal;
  logic [31:0] instr_count;
  logic [3:0]  state_dbg;

  always #5 clk = ~clk;

  mc_control_fsm #(.INSTR_CNT_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .alu_op      (alu_op),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_source   (pc_source),
    .pc_en       (pc_en),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .retired     (retired),
    .illegal     (illegal),
    .instr_count (instr_count),
    .state_dbg   (state_dbg)
  );

  typedef struct packed {
    int       lat;
    int       n_regw;
    logic     regw_dst;
    logic     regw_m2r;
    int       n_memrd;
    int       n_memwr;
    int       n_pcen;
    logic     chk_alu;
    logic [2:0] alu;
    logic     ill;
    logic     is_mem;
  } exp_t;

  typedef struct packed {
    int       lat;
    int       n_regw;
    logic     regw_dst;
    logic     regw_m2r;
    int       n_memrd;
    int       n_memwr;
    int       n_pcen;
    int       n_irw;
    logic [2:0] alu_at;
    int       n_ill;
    int       n_ill_strobe;
    int       viol;
    int       n_ret;
  } obs_t;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         f;
    int         m;
    int         lat;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned model_count = 0;
  int          st_log[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Instruction-level expectations straight from the ISA-level behaviour.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                 input int f, input int m);
    exp_t e;
    logic fvalid;
    logic [2:0] ralu;
    e = '0;
    fvalid = 1'b1;
    ralu = 3'b000;
    case (fn)
      6'b100000: ralu = 3'b010;
      6'b100010: ralu = 3'b110;
      6'b100100: ralu = 3'b000;
      6'b100101: ralu = 3'b001;
      6'b101010: ralu = 3'b111;
      default:   fvalid = 1'b0;
    endcase
    e.n_memrd = f + 1;
    e.n_pcen  = 1;
    if (op == 6'b100011) begin
      e.lat = 5 + f + m; e.n_regw = 1; e.regw_m2r = 1'b1; e.n_memrd = f + 1 + m + 1;
      e.chk_alu = 1'b1; e.alu = 3'b010; e.is_mem = 1'b1;
    end else if (op == 6'b101011) begin
      e.lat = 4 + f + m; e.n_memwr = m + 1; e.chk_alu = 1'b1; e.alu = 3'b010;
      e.is_mem = 1'b1;
    end else if (op == 6'b000000 && fvalid) begin
      e.lat = 4 + f; e.n_regw = 1; e.regw_dst = 1'b1; e.chk_alu = 1'b1; e.alu = ralu;
    end else if (op == 6'b000100) begin
      e.lat = 3 + f; e.chk_alu = 1'b1; e.alu = 3'b110; e.n_pcen = z ? 2 : 1;
    end else if (op == 6'b001000) begin
      e.lat = 4 + f; e.n_regw = 1; e.chk_alu = 1'b1; e.alu = 3'b010;
    end else if (op == 6'b000010) begin
      e.lat = 3 + f; e.n_pcen = 2;
    end else begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // Entered #1 after the edge that starts FETCH; returns #1 after the edge that ends it.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int f, input int m, output obs_t o, output exp_t e);
    int  c;
    int  budget;
    bit  done;
    e = model(op, fn, z, f, m);
    o = '0;
    opcode = op;
    funct  = fn;
    zero   = z;
    budget = e.ill ? f + 12 : e.lat + 6;
    c = 0;
    done = 1'b0;
    while (!done && c < budget) begin
      if (c > 0 && retired) begin
        o.n_ret++;
        if (!e.ill) begin
          o.lat = c;
          done  = 1'b1;
        end
      end
      if (!done) begin
        mem_ready = (c >= f) && !(e.is_mem && c >= f + 3 && c < f + 3 + m);
        @(negedge clk);
        if (c < 16) st_log[c] = int'(state_dbg);
        if (reg_write) begin
          o.n_regw++; o.regw_dst = reg_dst; o.regw_m2r = mem_to_reg;
        end
        if (mem_read)  o.n_memrd++;
        if (mem_write) o.n_memwr++;
        if (pc_en)     o.n_pcen++;
        if (ir_write)  o.n_irw++;
        if (c == f + 2) o.alu_at = alu_op;
        if (illegal) begin
          o.n_ill++;
          if (mem_read || mem_write || reg_write || pc_en || ir_write || iord)
            o.n_ill_strobe++;
        end
        if ((mem_read && mem_write) || (reg_write && pc_en)) o.viol++;
        @(posedge clk);
        #1;
        c++;
      end
    end
  endtask

  task automatic check_instr(input string tag, input obs_t o, input exp_t e);
    if (e.ill) begin
      check({tag, ".ill_cycles"}, o.n_ill, 10);
      check({tag, ".ill_strobes"}, o.n_ill_strobe, 0);
      check({tag, ".ill_retire"}, o.n_ret, 0);
      check({tag, ".ill_regw"}, o.n_regw, 0);
      check({tag, ".ill_flag"}, illegal, 1);
      check({tag, ".ill_state"}, state_dbg, 13);
      check({tag, ".ill_count"}, instr_count, model_count);
    end else begin
      check({tag, ".latency"}, o.lat, e.lat);
      check({tag, ".regw"}, o.n_regw, e.n_regw);
      if (e.n_regw != 0) begin
        check({tag, ".reg_dst"}, o.regw_dst, e.regw_dst);
        check({tag, ".mem_to_reg"}, o.regw_m2r, e.regw_m2r);
      end
      check({tag, ".mem_read_cycles"}, o.n_memrd, e.n_memrd);
      check({tag, ".mem_write_cycles"}, o.n_memwr, e.n_memwr);
      check({tag, ".pc_en_cycles"}, o.n_pcen, e.n_pcen);
      check({tag, ".ir_write_cycles"}, o.n_irw, 1);
      if (e.chk_alu) check({tag, ".alu_op"}, o.alu_at, e.alu);
      check({tag, ".exclusive"}, o.viol, 0);
      check({tag, ".no_illegal"}, o.n_ill, 0);
      check({tag, ".back_to_fetch"}, state_dbg, 1);
      model_count++;
      check({tag, ".instr_count"}, instr_count, model_count);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset.state", state_dbg, 0);
      check("reset.outputs",
            {mem_read, mem_write, ir_write, pc_en, reg_write, iord, illegal, alu_op,
             alu_src_a, alu_src_b, pc_source, reg_dst, mem_to_reg, retired}, 0);
      check("reset.count", instr_count, 0);
    end
    rst_n = 1'b1;
    model_count = 0;
    #1;
    check("reset.hold_after_release", state_dbg, 0);
    @(posedge clk);
    #1;
    check("reset.to_fetch", state_dbg, 1);
  endtask

  vec_t tbl[12];
  obs_t o;
  exp_t e;

  initial begin
    tbl[0]  = '{op: 6'b000000, fn: 6'b100010, z: 1'b0, f: 0, m: 0, lat: 4};
    tbl[1]  = '{op: 6'b000000, fn: 6'b100000, z: 1'b1, f: 1, m: 0, lat: 5};
    tbl[2]  = '{op: 6'b000000, fn: 6'b100100, z: 1'b0, f: 0, m: 2, lat: 4};
    tbl[3]  = '{op: 6'b000000, fn: 6'b100101, z: 1'b0, f: 2, m: 0, lat: 6};
    tbl[4]  = '{op: 6'b000000, fn: 6'b101010, z: 1'b0, f: 0, m: 0, lat: 4};
    tbl[5]  = '{op: 6'b100011, fn: 6'b000000, z: 1'b0, f: 0, m: 0, lat: 5};
    tbl[6]  = '{op: 6'b100011, fn: 6'b000000, z: 1'b0, f: 0, m: 2, lat: 7};
    tbl[7]  = '{op: 6'b101011, fn: 6'b000000, z: 1'b0, f: 1, m: 1, lat: 6};
    tbl[8]  = '{op: 6'b000100, fn: 6'b000000, z: 1'b1, f: 0, m: 0, lat: 3};
    tbl[9]  = '{op: 6'b000100, fn: 6'b000000, z: 1'b0, f: 0, m: 0, lat: 3};
    tbl[10] = '{op: 6'b001000, fn: 6'b000000, z: 1'b0, f: 0, m: 0, lat: 4};
    tbl[11] = '{op: 6'b000010, fn: 6'b000000, z: 1'b1, f: 2, m: 0, lat: 5};

    do_reset();

    // R-type sub walks FETCH, DECODE, EXEC, ALUWB.
    run_instr(6'b000000, 6'b100010, 1'b0, 0, 0, o, e);
    check_instr("rsub", o, e);
    check("rsub.st0", st_log[0], 1);
    check("rsub.st1", st_log[1], 2);
    check("rsub.st2", st_log[2], 7);
    check("rsub.st3", st_log[3], 8);

    // lw with two wait cycles holds MEMRD for three cycles before MEMWB.
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 2, o, e);
    check_instr("lw_stall", o, e);
    check("lw_stall.st3", st_log[3], 4);
    check("lw_stall.st4", st_log[4], 4);
    check("lw_stall.st5", st_log[5], 4);
    check("lw_stall.st6", st_log[6], 5);

    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].f, tbl[i].m, o, e);
      check($sformatf("vec%0d.table_latency", i), o.lat, tbl[i].lat);
      check_instr($sformatf("vec%0d", i), o, e);
    end

    run_instr(6'b111111, 6'b000000, 1'b0, 1, 0, o, e);
    check_instr("ill_opcode", o, e);
    do_reset();
    run_instr(6'b000000, 6'b000111, 1'b0, 0, 0, o, e);
    check_instr("ill_funct", o, e);
    do_reset();

    for (int i = 0; i < 40; i++) begin
      logic [5:0] rop, rfn;
      int k;
      k = int'($urandom_range(0, 5));
      case (k)
        0: rop = 6'b100011;
        1: rop = 6'b101011;
        2: rop = 6'b000000;
        3: rop = 6'b000100;
        4: rop = 6'b001000;
        default: rop = 6'b000010;
      endcase
      case ($urandom_range(0, 4))
        0: rfn = 6'b100000;
        1: rfn = 6'b100010;
        2: rfn = 6'b100100;
        3: rfn = 6'b100101;
        default: rfn = 6'b101010;
      endcase
      run_instr(rop, rfn, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), o, e);
      check_instr($sformatf("rnd%0d", i), o, e);
    end

    // sw stalled in MEMWR, then reset lands mid-write.
    opcode = 6'b101011;
    funct = '0;
    mem_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("midrst.in_memwr", state_dbg, 6);
    check("midrst.write_before", mem_write, 1);
    rst_n = 1'b0;
    #1;
    check("midrst.write_dropped", mem_write, 0);
    check("midrst.iord_dropped", iord, 0);
    check("midrst.state", state_dbg, 0);
    check("midrst.count", instr_count, 0);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish before 1000000 ns");
    $fatal(1);
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS-subset main control unit.
- Sits directly upstream of the 32-bit ALU and drives its 3-bit operation code.
- Also drives every datapath and memory control strobe of the shared-memory multi-cycle datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback states, stalling on a memory ready handshake.

Parameters:
- INSTR_CNT_W, 32, width of retired-instruction counter (wraps modulo 2^INSTR_CNT_W).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26], stable from IR write until next FETCH.
- funct  in  6  IR[5:0].
- zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes current read/write this cycle.
- alu_op  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- pc_en  out  1  PC load enable.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- mem_read, mem_write  out  1 each  memory strobes.
- ir_write  out  1  instruction register load.
- reg_dst  out  1  0 = rt, 1 = rd.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- retired  out  1  one-cycle pulse per completed instruction.
- illegal  out  1  sticky illegal-instruction flag.
- instr_count  out  INSTR_CNT_W  retired-instruction count.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (rst_n low, async): state = RESET (0), instr_count = 0.
  - All outputs 0, alu_op = 000.
  - RESET -> FETCH on the first clock edge after release.
- Outputs are Moore, decoded from state only, except:
  - pc_en = pc_write | (pc_write_cond & zero).
  - FETCH strobes gated by mem_ready.
- States and encodings: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, EXEC 7, ALUWB 8, BRANCH 9, ADDIEX 10, ADDIWB 11, JUMP 12, ILLEGAL 13.
- FETCH:
  - mem_read = 1, alu_src_a = 0, alu_src_b = 01, alu_op = 010, pc_source = 00.
  - ir_write and pc_write only while mem_ready = 1.
  - Holds while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 010. Next state by opcode:
  - 100011 (lw) / 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC, but only if funct is supported; otherwise ILLEGAL.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JUMP.
  - Any other opcode -> ILLEGAL.
- MEMADR:
  - Controls: alu_src_a = 1, alu_src_b = 10, alu_op = 010.
  - Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord = 1, mem_read = 1. Holds until mem_ready, then -> MEMWB.
- MEMWR: iord = 1, mem_write = 1. Holds until mem_ready, then -> FETCH.
- MEMWB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. -> FETCH.
- EXEC:
  - alu_src_a = 1, alu_src_b = 00.
  - alu_op from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - -> ALUWB.
- ALUWB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. -> FETCH.
- BRANCH:
  - Controls: alu_src_a = 1, alu_src_b = 00, alu_op = 110, pc_source = 01, pc_write_cond = 1.
  - -> FETCH.
- ADDIEX: alu_src_a = 1, alu_src_b = 10, alu_op = 010. -> ADDIWB.
- ADDIWB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. -> FETCH.
- JUMP: pc_source = 10, pc_write = 1. -> FETCH.
- ILLEGAL:
  - All strobes 0, illegal = 1.
  - Absorbing state; only reset exits it.
- Latency with zero-wait memory, counted in cycles from FETCH entry: R 4, lw 5, sw 4, beq 3, j 3, addi 4. Each mem_ready = 0 cycle adds one.
- retired: asserted for one cycle on the edge entering FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP. instr_count increments on that same edge.
- mem_read and mem_write are never both 1. reg_write and pc_en are never both 1 outside JUMP/BRANCH rules.
- Reset asserted mid-instruction: immediate return to RESET and all strobes 0. No partial write may complete after rst_n falls.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum.
  - opcode and funct constants.
  - ALU op codes (000/001/010/110/111), shared with the ALU.
  - alu_src_b and pc_source encodings.
- Sub-module alu_op_decode: combinational funct -> {alu_op, funct_valid}, instantiated for EXEC.

Test Plan:
- Reset: hold rst_n = 0 three cycles, release.
  - Expect state_dbg 0 -> 1, all strobes 0 during reset, instr_count = 0.
- R-type sub: opcode 000000, funct 100010, mem_ready = 1.
  - Expect states 1, 2, 7, 8, 1.
  - alu_op = 110 in EXEC, reg_write = 1 and reg_dst = 1 in ALUWB.
  - retired pulse, instr_count = 1.
- lw with stall: opcode 100011, mem_ready = 0 for 2 cycles in MEMRD.
  - Expect MEMRD held 3 cycles with iord = 1, mem_read = 1.
  - MEMWB then has mem_to_reg = 1; total latency 7 cycles.
- beq: opcode 000100.
  - zero = 1 -> pc_en = 1 with pc_source = 01 in BRANCH.
  - Repeat with zero = 0 -> pc_en = 0; both retire after 3 cycles.
- Illegal: opcode 111111, then R-type with funct 000111.
  - Expect state 13, illegal = 1, no strobes, no retire.
  - Remains in ILLEGAL for 10 cycles until rst_n pulse.
- Mid-op reset: assert rst_n low during MEMWR with mem_ready = 0.
  - Expect mem_write drops the same cycle (async).
  - state_dbg = 0, instr_count = 0.
